// File: rtl/nibble_demux_capture_pkg.sv
// nibble_pkg: shared types and default sizes for the nibble demux capture block
package nibble_pkg;
   localparam int W_DEF = 4;
   localparam int N_DEF = 8;
   typedef logic [W_DEF-1:0] nibble_t;
   typedef logic [$clog2(N_DEF)-1:0] slot_idx_t;
   typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/nibble_demux_capture_if.sv
// nibble_demux_capture_if: producer stream in, complete frame out
// slave modport is the capture block; master modport is the producer/consumer side
interface nibble_demux_capture_if #(parameter int W = 4, parameter int N = 8);
   logic                   in_valid;
   logic [W-1:0]           in_data;
   logic                   in_ready;
   logic [$clog2(N)-1:0]   cur_slot;
   logic [N*W-1:0]         slots;
   logic                   out_valid;
   logic                   out_ready;
   modport slave (input in_valid, in_data, out_ready, output in_ready, cur_slot, slots, out_valid);
   modport master (output in_valid, in_data, out_ready, input in_ready, cur_slot, slots, out_valid);
endinterface

// File: rtl/nibble_demux_capture_slot_counter.sv
// slot_counter: modulo-N counter with enable, sync clear and terminal count
// ports: clk, reset, clr (sync clear), en (count), cnt (current value), tc (cnt == N-1)
module slot_counter #(parameter int N = 8) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   output logic [$clog2(N)-1:0] cnt,
   output logic                 tc
);
   localparam int CW = $clog2(N);
   // N is a power of two, so natural overflow gives the modulo-N wrap
   always_ff @(posedge clk)
      if (reset || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign tc = (cnt == CW'(N - 1));
endmodule

// File: rtl/nibble_demux_capture.sv
// nibble_demux_capture: distributes a nibble stream into N slot registers and holds the full frame
// ports: clk, reset (sync, active-high), restart (sync frame abort), bus (slave side of the stream/frame interface)
module nibble_demux_capture
   import nibble_pkg::*;
#(parameter int W = W_DEF, parameter int N = N_DEF) (
   input logic clk,
   input logic reset,
   input logic restart,
   nibble_demux_capture_if.slave bus
);
   state_t state, state_nx;
   logic [$clog2(N)-1:0] cur;
   logic [N*W-1:0] slots_q;
   logic accept, tc, wr;
   assign accept = (state == FILL) && bus.in_valid;
   // restart discards a coincident accept: no slot write, no count
   assign wr = accept && !restart;
   slot_counter #(.N(N)) u_cnt (
      .clk(clk), .reset(reset), .clr(restart), .en(wr), .cnt(cur), .tc(tc)
   );
   always_comb begin
      state_nx = state;
      state_nx = restart ? FILL :
                 (state == FILL) ? ((wr && tc) ? HOLD : FILL) :
                 (bus.out_ready ? FILL : HOLD);
   end
   always_ff @(posedge clk)
      if (reset) state <= FILL;
      else state <= state_nx;
   always_ff @(posedge clk)
      if (reset) slots_q <= '0;
      else if (wr) slots_q[cur*W +: W] <= bus.in_data;
   assign bus.in_ready = (state == FILL);
   assign bus.out_valid = (state == HOLD);
   assign bus.cur_slot = cur;
   assign bus.slots = slots_q;
endmodule

// File: doc/nibble_demux_capture.md
# nibble_demux_capture

Write-side counterpart of the 8-to-1 nibble selector used on the display datapath. It accepts a serial stream of 4-bit values over a valid/ready handshake and distributes them, in order, into eight slot registers (slot 0..7, the A..H inputs of the selector). When all eight slots have been written, it presents a complete frame and holds it until the consumer acknowledges.

## Interface
Parameters:
- W, 4, width of one slot value in bits
- N, 8, number of slots; power of two, at least 2

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- restart  in  1  synchronous frame abort; highest priority after reset
- in_valid  in  1  producer has a value on in_data
- in_data  in  W  value to be written into the current slot
- in_ready  out  1  block can accept a value this cycle
- cur_slot  out  $clog2(N)  index of the slot the next accepted value goes to
- slots  out  N*W  all slot registers; slot k occupies bits [k*W+W-1 : k*W]
- out_valid  out  1  slots hold a complete frame
- out_ready  in  1  consumer takes the frame

## Operation
- Two states: FILL and HOLD.
- FILL:
  - in_ready = 1, out_valid = 0.
  - An accept occurs when in_valid && in_ready at the clock edge.
  - On accept, slot[cur_slot] <= in_data and cur_slot increments.
  - An accept with cur_slot = N-1 writes slot N-1, wraps cur_slot to 0 and moves to HOLD.
- HOLD:
  - in_ready = 0, out_valid = 1. Slots and cur_slot are frozen.
  - When out_valid && out_ready at an edge, the block returns to FILL.
  - in_valid is ignored in HOLD.
- Slots not yet written in the current frame keep their previous-frame values. They are never cleared except by reset.
- restart (any state): state goes to FILL, cur_slot to 0, out_valid to 0. Slot contents are unchanged. A simultaneous accept is discarded.
- reset: state goes to FILL, cur_slot to 0, all slots to 0. reset overrides restart.
- in_data is unconstrained when in_valid = 0. No arithmetic beyond the modulo-N increment of cur_slot.

## Timing
Reset values:
- in_ready = 1, out_valid = 0, cur_slot = 0, slots = 0.

Latency:
- A written slot value is visible on slots the cycle after its accept edge.
- out_valid rises the cycle after the accept of slot N-1.
- in_ready falls in the same cycle that out_valid rises. Both are Moore outputs decoded from state.

Throughput:
- The HOLD-to-FILL handshake costs one cycle. Minimum frame period is N+1 cycles with out_ready tied high.

Handshake rules:
- The producer must hold in_data stable while in_valid = 1 and in_ready = 0.
- in_ready does not depend combinationally on in_valid.
- out_valid stays high until it is acknowledged or restart/reset occurs.

Boundary cases:
- Wrap from N-1 to 0 happens only on an accept.
- reset or restart mid-frame drops the partial frame.
- restart during HOLD withdraws out_valid without requiring an acknowledgement.

## Structure
- Shared package nibble_pkg holds:
  - typedef nibble_t (logic [W-1:0])
  - typedef slot_idx_t (logic [$clog2(N)-1:0])
  - enum state_t {FILL, HOLD}
  - localparams for defaults W=4, N=8
- One sub-module, slot_counter: modulo-N counter with enable, synchronous clear and a terminal-count output. It drives cur_slot and the FILL→HOLD transition.
- The slot register array and the FSM live in the top module.

## Test plan
- Reset, then stream in_valid=1 with data 1,2,…,8 and out_ready=0:
  - in_ready=1 for 8 cycles.
  - out_valid=1 and slots=32'h87654321 on the 9th cycle.
  - in_ready=0 thereafter.
- From that HOLD state, pulse out_ready for one cycle:
  - Next cycle: out_valid=0, in_ready=1, cur_slot=0.
  - Stream A..H; slots=32'hHGFEDCBA-equivalent (32'hFEDCBA98 for data 8..F), out_valid after 8 accepts.
- Accept 3 values (5,6,7), then assert restart together with in_valid and data 9:
  - Next cycle cur_slot=0; slots[11:0] still 12'h765; 9 not written.
  - Next 8 accepts complete the frame normally.
- In HOLD, drive in_valid=1 with data F for 5 cycles:
  - slots unchanged, cur_slot=0, out_valid stays 1.
- Random in_valid gaps with out_ready tied to 1 across 3 frames:
  - Each frame equals its accepted data.
  - Exactly one out_valid cycle per frame.
  - No value is lost or duplicated.
- Assert reset during HOLD with restart=1:
  - Next cycle slots=0, out_valid=0, in_ready=1, cur_slot=0.
